mem_arbiter: RTL and testbench

Shares the single data-memory port between the instruction-fetch requester (port 0) and the load/store unit (port 1). It sits between both requesters and the memory. Requesters use the same protocol as the memory: valid held until ready, then one response flagged by rvalid. One transaction is outstanding at a time. Arbitration is round-robin with a priority override.

---
 rtl/core_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 28 ++
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_pkg: shared types and constants for the memory arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
package core_pkg;

   typedef enum logic [1:0] {
      ArbIdle  = 2'd0,
      ArbIssue = 2'd1,
      ArbResp  = 2'd2
   } arb_state_e;

   localparam logic PortFetch = 1'b0;
   localparam logic PortData  = 1'b1;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2: combinational two-way winner select, round-robin or data-priority.
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_arb2
   import core_pkg::*;
#(
   parameter int unsigned DataPrio = 1
) (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic       winner_o
);

   always_comb begin
      winner_o = PortFetch;
      case (req_i)
         2'b01:   winner_o = PortFetch;
         2'b10:   winner_o = PortData;
         // Tie: fixed data priority, or the port that was not served last.
         2'b11:   winner_o = (DataPrio != 0) ? PortData : ~last_i;
         default: winner_o = PortFetch;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter: shares one memory port between fetch (0) and load/store (1),
// one outstanding transaction at a time.  Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
   import core_pkg::*;
#(
   parameter int unsigned DataPrio = 1,
   parameter int unsigned Xlen     = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [1:0]                 req_valid_i,
   output logic [1:0]                 req_ready_o,
   input  logic [1:0][Xlen-1:0]       req_addr_i,
   input  logic [1:0][Xlen-1:0]       req_wdata_i,
   input  logic [1:0][Xlen/8-1:0]     req_wmask_i,
   output logic [Xlen-1:0]            req_rdata_o,
   output logic [1:0]                 req_rvalid_o,
   output logic                       mem_valid_o,
   input  logic                       mem_ready_i,
   output logic [Xlen-1:0]            mem_addr_o,
   output logic [Xlen-1:0]            mem_wdata_o,
   output logic [Xlen/8-1:0]          mem_wmask_o,
   input  logic [Xlen-1:0]            mem_rdata_i,
   input  logic                       mem_rvalid_i,
   output logic                       spurious_o
);

   arb_state_e state_q, state_d;
   logic       grant_q, grant_d;
   logic       last_q,  last_d;
   logic       winner;
   logic       in_issue;
   logic       in_resp;

   rr_arb2 #(
      .DataPrio (DataPrio)
   ) u_rr_arb2 (
      .req_i    (req_valid_i),
      .last_i   (last_q),
      .winner_o (winner)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         ArbIdle: begin
            if (|req_valid_i) begin
               grant_d = winner;
               state_d = ArbIssue;
            end
         end
         ArbIssue: begin
            // A withdrawn request aborts before any memory access happens.
            if (!req_valid_i[grant_q]) begin
               state_d = ArbIdle;
            end else if (mem_ready_i) begin
               last_d  = grant_q;
               state_d = ArbResp;
            end
         end
         ArbResp: begin
            if (mem_rvalid_i) begin
               state_d = ArbIdle;
            end
         end
         default: state_d = ArbIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ArbIdle;
         grant_q <= PortFetch;
         last_q  <= PortFetch;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign in_issue = (state_q == ArbIssue);
   assign in_resp  = (state_q == ArbResp);

   assign mem_valid_o  = in_issue & req_valid_i[grant_q];
   assign mem_addr_o   = req_addr_i[grant_q];
   assign mem_wdata_o  = req_wdata_i[grant_q];
   assign mem_wmask_o  = req_wmask_i[grant_q];

   assign req_ready_o  = (in_issue && mem_ready_i) ? port_onehot(grant_q) : 2'b00;
   assign req_rvalid_o = (in_resp && mem_rvalid_i) ? port_onehot(grant_q) : 2'b00;
   assign req_rdata_o  = mem_rdata_i;

   // Reset gating keeps the flag quiet while the memory is still draining.
   assign spurious_o   = rst_ni & mem_rvalid_i & ~in_resp;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter: table-driven bench, priority and round-robin instances.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
   import core_pkg::*;

   localparam int XL = 32;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]          req_valid_i = '0;
   logic [1:0][XL-1:0]  req_addr_i  = '0;
   logic [1:0][XL-1:0]  req_wdata_i = '0;
   logic [1:0][XL/8-1:0] req_wmask_i = '0;
   logic                mem_ready_i  = 1'b0;
   logic [XL-1:0]       mem_rdata_i  = '0;
   logic                mem_rvalid_i = 1'b0;

   logic [1:0]    ready_p, rvalid_p, ready_r, rvalid_r;
   logic [XL-1:0] rdata_p, maddr_p, mwdata_p, rdata_r, maddr_r, mwdata_r;
   logic [3:0]    mwmask_p, mwmask_r;
   logic          mvalid_p, spur_p, mvalid_r, spur_r;

   mem_arbiter #(.DataPrio(1), .Xlen(XL)) dut_p (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(ready_p),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
      .req_rdata_o(rdata_p), .req_rvalid_o(rvalid_p),
      .mem_valid_o(mvalid_p), .mem_ready_i(mem_ready_i),
      .mem_addr_o(maddr_p), .mem_wdata_o(mwdata_p), .mem_wmask_o(mwmask_p),
      .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
      .spurious_o(spur_p)
   );

   mem_arbiter #(.DataPrio(0), .Xlen(XL)) dut_r (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(ready_r),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
      .req_rdata_o(rdata_r), .req_rvalid_o(rvalid_r),
      .mem_valid_o(mvalid_r), .mem_ready_i(mem_ready_i),
      .mem_addr_o(maddr_r), .mem_wdata_o(mwdata_r), .mem_wmask_o(mwmask_r),
      .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
      .spurious_o(spur_r)
   );

   typedef struct {
      logic [1:0]  vld;
      logic        exp_p;
      logic        exp_r;
      int          stall;
      int          rdly;
      logic        late0;
      logic [31:0] a1;
      logic [3:0]  m1;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic              port_p;
      logic              port_r;
      logic [1:0][31:0]  addr;
      logic [1:0][31:0]  wdata;
      logic [1:0][3:0]   wmask;
      logic [31:0]       rdata;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[9];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] vld, input logic ep, input logic er,
                               input int stall, input int rdly, input logic late0,
                               input logic [31:0] a1, input logic [3:0] m1,
                               input logic [31:0] rdata);
      vec_t v;
      v.vld = vld; v.exp_p = ep; v.exp_r = er; v.stall = stall; v.rdly = rdly;
      v.late0 = late0; v.a1 = a1; v.m1 = m1; v.rdata = rdata;
      return v;
   endfunction

   task automatic chk_issue(input string tag, input exp_t g, input logic rdy);
      chk({tag, "/p mem_valid"}, 32'(mvalid_p), 32'd1);
      chk({tag, "/p mem_addr"},  maddr_p, g.addr[g.port_p]);
      chk({tag, "/p mem_wdata"}, mwdata_p, g.wdata[g.port_p]);
      chk({tag, "/p mem_wmask"}, 32'(mwmask_p), 32'(g.wmask[g.port_p]));
      chk({tag, "/p req_ready"}, 32'(ready_p), 32'(rdy ? port_onehot(g.port_p) : 2'b00));
      chk({tag, "/r mem_valid"}, 32'(mvalid_r), 32'd1);
      chk({tag, "/r mem_addr"},  maddr_r, g.addr[g.port_r]);
      chk({tag, "/r mem_wdata"}, mwdata_r, g.wdata[g.port_r]);
      chk({tag, "/r mem_wmask"}, 32'(mwmask_r), 32'(g.wmask[g.port_r]));
      chk({tag, "/r req_ready"}, 32'(ready_r), 32'(rdy ? port_onehot(g.port_r) : 2'b00));
   endtask

   // Entered just after a clock edge with both DUTs in Idle.
   task automatic run_vec(input vec_t v, input int i);
      exp_t  e;
      exp_t  g;
      string tag;
      tag = $sformatf("v%0d", i);
      req_valid_i    = v.vld;
      req_addr_i[0]  = 32'h2000 + 32'(i * 4);
      req_addr_i[1]  = v.a1;
      req_wdata_i[0] = 32'hA000_0000 + 32'(i);
      req_wdata_i[1] = 32'hB000_0000 + 32'(i);
      req_wmask_i[0] = 4'h0;
      req_wmask_i[1] = v.m1;
      mem_ready_i    = 1'b0;
      mem_rvalid_i   = 1'b0;
      mem_rdata_i    = 32'h5555_5555;
      e.port_p = v.exp_p;
      e.port_r = v.exp_r;
      e.addr   = req_addr_i;
      e.wdata  = req_wdata_i;
      e.wmask  = req_wmask_i;
      e.rdata  = v.rdata;
      sb.push_back(e);

      @(negedge clk);
      chk({tag, " idle mem_valid"}, 32'({mvalid_p, mvalid_r}), 32'd0);
      @(posedge clk); #1;
      for (int s = 0; s < v.stall; s++) begin
         if (s == 1 && v.late0) req_valid_i[0] = 1'b1;
         @(negedge clk);
         chk_issue({tag, " stall"}, e, 1'b0);
         @(posedge clk); #1;
      end
      mem_ready_i = 1'b1;
      @(negedge clk);
      chk({tag, " scoreboard nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         g = sb.pop_front();
         chk_issue({tag, " hs"}, g, 1'b1);
      end else begin
         g = e;
      end
      @(posedge clk); #1;
      mem_ready_i = 1'b0;
      for (int d = 0; d < v.rdly; d++) begin
         @(negedge clk);
         chk({tag, " early rvalid"}, 32'({rvalid_p, rvalid_r}), 32'd0);
         @(posedge clk); #1;
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = v.rdata;
      @(negedge clk);
      chk({tag, "/p rvalid"}, 32'(rvalid_p), 32'(port_onehot(g.port_p)));
      chk({tag, "/r rvalid"}, 32'(rvalid_r), 32'(port_onehot(g.port_r)));
      chk({tag, "/p rdata"}, rdata_p, g.rdata);
      chk({tag, "/r rdata"}, rdata_r, g.rdata);
      chk({tag, " spurious"}, 32'({spur_p, spur_r}), 32'd0);
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
   endtask

   initial begin
      // Round-robin instance starts with last = 0, so its first tie goes to port 1.
      vecs[0] = mk(2'b10, 1'b1, 1'b1, 0, 1, 1'b0, 32'h0000_0100, 4'h0, 32'hDEAD_BEEF);
      vecs[1] = mk(2'b01, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0000_0104, 4'h0, 32'h1234_5678);
      vecs[2] = mk(2'b11, 1'b1, 1'b1, 0, 0, 1'b0, 32'h0000_0200, 4'h3, 32'h0000_0002);
      vecs[3] = mk(2'b11, 1'b1, 1'b0, 0, 1, 1'b0, 32'h0000_0204, 4'hC, 32'h0000_0003);
      vecs[4] = mk(2'b11, 1'b1, 1'b1, 0, 0, 1'b0, 32'h0000_0208, 4'h0, 32'h0000_0004);
      vecs[5] = mk(2'b11, 1'b1, 1'b0, 0, 2, 1'b0, 32'h0000_020C, 4'h1, 32'h0000_0005);
      vecs[6] = mk(2'b10, 1'b1, 1'b1, 5, 2, 1'b1, 32'h0000_0300, 4'hF, 32'hCAFE_F00D);
      vecs[7] = mk(2'b01, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0000_0304, 4'h0, 32'h0BAD_0BAD);
      vecs[8] = mk(2'b11, 1'b1, 1'b1, 1, 0, 1'b0, 32'h0000_0308, 4'h0, 32'h0000_0008);

      req_addr_i[0] = 32'h1111_0000;
      req_addr_i[1] = 32'h2222_0000;
      mem_rvalid_i  = 1'b1;
      #2;
      chk("reset mem_valid", 32'({mvalid_p, mvalid_r}), 32'd0);
      chk("reset req_ready", 32'({ready_p, ready_r}), 32'd0);
      chk("reset req_rvalid", 32'({rvalid_p, rvalid_r}), 32'd0);
      chk("reset spurious", 32'({spur_p, spur_r}), 32'd0);
      chk("reset mem_addr/p", maddr_p, 32'h1111_0000);
      chk("reset mem_addr/r", maddr_r, 32'h1111_0000);
      mem_rvalid_i = 1'b0;
      #20;
      rst_ni = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Abort in Issue, then a stray response in Idle.
      req_valid_i = 2'b01;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid_i = 2'b00;
      @(negedge clk);
      chk("abort mem_valid", 32'({mvalid_p, mvalid_r}), 32'd0);
      @(posedge clk); #1;
      mem_rvalid_i = 1'b1;
      @(negedge clk);
      chk("spurious pulse", 32'({spur_p, spur_r}), 32'b11);
      chk("spurious rvalid", 32'({rvalid_p, rvalid_r}), 32'd0);
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      @(negedge clk);
      chk("spurious single", 32'({spur_p, spur_r}), 32'd0);
      chk("post-abort idle", 32'({mvalid_p, mvalid_r}), 32'd0);

      // Asynchronous reset while waiting in Resp.
      @(posedge clk); #1;
      req_addr_i[0] = 32'h4444_0000;
      req_addr_i[1] = 32'h5555_0000;
      req_valid_i   = 2'b10;
      @(posedge clk); #1;
      mem_ready_i = 1'b1;
      @(posedge clk); #1;
      mem_ready_i  = 1'b0;
      req_valid_i  = 2'b00;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h7777_7777;
      #1;
      chk("pre-reset rvalid/p", 32'(rvalid_p), 32'b10);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("async reset rvalid", 32'({rvalid_p, rvalid_r}), 32'd0);
      chk("async reset spurious", 32'({spur_p, spur_r}), 32'd0);
      chk("async reset mem_valid", 32'({mvalid_p, mvalid_r}), 32'd0);
      chk("async reset mem_addr", maddr_p, 32'h4444_0000);
      @(negedge clk); #1;
      rst_ni = 1'b1;
      #1;
      chk("late rvalid spurious", 32'({spur_p, spur_r}), 32'b11);
      chk("late rvalid dropped", 32'({rvalid_p, rvalid_r}), 32'd0);
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      @(negedge clk);
      chk("after late rvalid", 32'({spur_p, spur_r}), 32'd0);

      chk("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
